// File: rtl/regfile_mp_pkg.sv
// Purpose : shared core definitions used by the register file and its scoreboard.
// Latency : n/a (constants and helper functions only).
// Backpressure: n/a.
// Contents: core data/register-count constants and the address-width helper.
package regfile_mp_pkg;

    // Core-wide architectural constants.
    localparam int CORE_XLEN = 32;
    localparam int CORE_NREG = 32;
    localparam int CORE_ILEN = 32;

    // Register-file defaults track the core constants.
    localparam int RF_XLEN = CORE_XLEN;
    localparam int RF_NREG = CORE_NREG;

    // Register address width; a single-register file still needs one address bit.
    function automatic int rf_addr_width(input int nreg);
        return (nreg > 1) ? $clog2(nreg) : 1;
    endfunction

    localparam int RF_AW = rf_addr_width(RF_NREG);

endpackage

// File: rtl/rf_scoreboard.sv
// Purpose : per-register busy tracking (producer issued, result not yet written).
// Latency : busy_vec updates at the next clk edge; rbusy is combinational.
// Backpressure: none; sets and clears are accepted every cycle.
// Ports   : clk/rst (sync, active-high); raddr -> rbusy per read port;
//           wen/waddr clear bits; set_en/set_addr set a bit; busy_vec is the state.
module rf_scoreboard
    import regfile_mp_pkg::*;
#(
    parameter int NREG     = RF_NREG,
    parameter int NRP      = 2,
    parameter int NWP      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    parameter int AW       = rf_addr_width(NREG)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NRP*AW-1:0] raddr,
    input  logic [NWP-1:0]    wen,
    input  logic [NWP*AW-1:0] waddr,
    input  logic              set_en,
    input  logic [AW-1:0]     set_addr,
    output logic [NRP-1:0]    rbusy,
    output logic [NREG-1:0]   busy_vec
);

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [AW-1:0]   wa [NWP];
    logic            set_ok;

    for (genvar p = 0; p < NWP; p++) begin : g_wp
        assign wa[p] = waddr[p*AW +: AW];
    end

    // Register 0 never becomes busy when it is hardwired to zero.
    assign set_ok = set_en && !((ZERO_REG != 0) && (set_addr == '0));

    // Clears are applied first so a same-cycle set on the same register wins:
    // the newly issued producer owns the register from here on.
    always_comb begin
        busy_d = busy_q;
        for (int p = 0; p < NWP; p++) begin
            if (wen[p]) begin
                busy_d[wa[p]] = 1'b0;
            end
        end
        if (set_ok) begin
            busy_d[set_addr] = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

    assign busy_vec = busy_q;

    for (genvar r = 0; r < NRP; r++) begin : g_rp
        logic [AW-1:0] ra;
        logic          fwd;
        logic          set_here;

        assign ra = raddr[r*AW +: AW];

        // A forwarded write means the reader already has the result, unless a
        // new producer claims the same register in this very cycle.
        always_comb begin
            fwd = 1'b0;
            if (BYPASS != 0) begin
                for (int p = 0; p < NWP; p++) begin
                    if (wen[p] && (wa[p] == ra)) begin
                        fwd = 1'b1;
                    end
                end
            end
        end

        assign set_here = set_en && (set_addr == ra);
        assign rbusy[r] = (fwd && !set_here) ? 1'b0 : busy_q[ra];
    end

endmodule

// File: rtl/regfile_mp.sv
// Purpose : multi-ported architectural register file with write forwarding and scoreboard.
// Latency : reads combinational (0 cycles); writes and busy updates land at the next clk edge.
// Backpressure: none; every port is serviced every cycle.
// Ports   : clk/rst (sync, active-high); raddr -> rdata/rbusy per read port;
//           wen/waddr/wdata per write port; set_en/set_addr mark a register busy;
//           busy_vec exposes the registered scoreboard.
module regfile_mp
    import regfile_mp_pkg::*;
#(
    parameter int XLEN     = RF_XLEN,
    parameter int NREG     = RF_NREG,
    parameter int NRP      = 2,
    parameter int NWP      = 2,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 1,
    parameter int AW       = rf_addr_width(NREG)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NRP*AW-1:0]   raddr,
    output logic [NRP*XLEN-1:0] rdata,
    output logic [NRP-1:0]      rbusy,
    input  logic [NWP-1:0]      wen,
    input  logic [NWP*AW-1:0]   waddr,
    input  logic [NWP*XLEN-1:0] wdata,
    input  logic                set_en,
    input  logic [AW-1:0]       set_addr,
    output logic [NREG-1:0]     busy_vec
);

    logic [XLEN-1:0] regs [NREG];
    logic [AW-1:0]   wa   [NWP];
    logic [XLEN-1:0] wd   [NWP];

    for (genvar p = 0; p < NWP; p++) begin : g_wp
        assign wa[p] = waddr[p*AW +: AW];
        assign wd[p] = wdata[p*XLEN +: XLEN];
    end

    // Storage: each register picks its write data from the highest-index
    // enabled port that targets it.
    for (genvar i = 0; i < NREG; i++) begin : g_reg
        if ((ZERO_REG != 0) && (i == 0)) begin : g_zero
            assign regs[i] = '0;
        end else begin : g_store
            logic            we;
            logic [XLEN-1:0] wval;
            logic [XLEN-1:0] q;

            always_comb begin
                we   = 1'b0;
                wval = '0;
                for (int p = 0; p < NWP; p++) begin
                    if (wen[p] && (wa[p] == AW'(i))) begin
                        we   = 1'b1;
                        wval = wd[p];
                    end
                end
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    q <= '0;
                end else if (we) begin
                    q <= wval;
                end
            end

            assign regs[i] = q;
        end
    end

    // Read ports: array value, overridden by the highest-index matching write
    // when forwarding is enabled; register 0 always reads zero if hardwired.
    for (genvar r = 0; r < NRP; r++) begin : g_rp
        logic [AW-1:0]   ra;
        logic [XLEN-1:0] rd;

        assign ra = raddr[r*AW +: AW];

        always_comb begin
            rd = regs[ra];
            if (BYPASS != 0) begin
                for (int p = 0; p < NWP; p++) begin
                    if (wen[p] && (wa[p] == ra)) begin
                        rd = wd[p];
                    end
                end
            end
            if ((ZERO_REG != 0) && (ra == '0)) begin
                rd = '0;
            end
        end

        assign rdata[r*XLEN +: XLEN] = rd;
    end

    rf_scoreboard #(
        .NREG     (NREG),
        .NRP      (NRP),
        .NWP      (NWP),
        .BYPASS   (BYPASS),
        .ZERO_REG (ZERO_REG),
        .AW       (AW)
    ) u_sb (
        .clk      (clk),
        .rst      (rst),
        .raddr    (raddr),
        .wen      (wen),
        .waddr    (waddr),
        .set_en   (set_en),
        .set_addr (set_addr),
        .rbusy    (rbusy),
        .busy_vec (busy_vec)
    );

endmodule

// File: tb/tb_regfile_mp.sv
// Purpose : directed self-checking bench for regfile_mp (forwarding and non-forwarding builds).
// Latency : checks taken 1-2 time units after input changes, away from clk edges.
// Backpressure: n/a.
module tb_regfile_mp;

    logic        clk = 1'b0;
    logic        rst;
    logic [9:0]  raddr;
    logic [1:0]  wen;
    logic [9:0]  waddr;
    logic [63:0] wdata;
    logic        set_en;
    logic [4:0]  set_addr;

    logic [63:0] rdata_b,  rdata_n;
    logic [1:0]  rbusy_b,  rbusy_n;
    logic [31:0] busy_b,   busy_n;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    regfile_mp #(.BYPASS(1)) dut (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_b), .rbusy(rbusy_b),
        .wen(wen), .waddr(waddr), .wdata(wdata), .set_en(set_en),
        .set_addr(set_addr), .busy_vec(busy_b)
    );

    regfile_mp #(.BYPASS(0)) dut_nb (
        .clk(clk), .rst(rst), .raddr(raddr), .rdata(rdata_n), .rbusy(rbusy_n),
        .wen(wen), .waddr(waddr), .wdata(wdata), .set_en(set_en),
        .set_addr(set_addr), .busy_vec(busy_n)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wen    = 2'b00;
        set_en = 1'b0;
    endtask

    task automatic wr(input int port, input logic [4:0] a, input logic [31:0] d);
        wen[port]            = 1'b1;
        waddr[port*5 +: 5]   = a;
        wdata[port*32 +: 32] = d;
    endtask

    task automatic rd(input logic [4:0] a0, input logic [4:0] a1);
        raddr = {a1, a0};
    endtask

    task automatic test_reset();
        rst = 1'b1; idle(); rd(5'd5, 5'd31);
        waddr = '0; wdata = '0; set_addr = '0;
        tick();
        rst = 1'b0;
        #1;
        checks++; if (busy_b !== 32'h0) begin errors++; $display("FAIL reset_busy: got %h want 0", busy_b); end
        checks++; if (busy_n !== 32'h0) begin errors++; $display("FAIL reset_busy_nb: got %h want 0", busy_n); end
        checks++; if (rdata_b !== 64'h0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata_b); end
        checks++; if (rbusy_b !== 2'b00) begin errors++; $display("FAIL reset_rbusy: got %b want 00", rbusy_b); end
    endtask

    task automatic test_write_read();
        wr(0, 5'd5, 32'hDEADBEEF);
        tick();
        idle(); rd(5'd5, 5'd5);
        #1;
        checks++; if (rdata_b[31:0] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_p0: got %h want deadbeef", rdata_b[31:0]); end
        checks++; if (rdata_b[63:32] !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_rd_p1: got %h want deadbeef", rdata_b[63:32]); end
        checks++; if (rdata_n !== 64'hDEADBEEF_DEADBEEF) begin errors++; $display("FAIL wr_rd_nb: got %h want deadbeefdeadbeef", rdata_n); end
        checks++; if (rbusy_b !== 2'b00) begin errors++; $display("FAIL wr_rd_rbusy: got %b want 00", rbusy_b); end
    endtask

    task automatic test_same_addr();
        wr(0, 5'd7, 32'h11);
        wr(1, 5'd7, 32'h22);
        tick();
        idle(); rd(5'd7, 5'd7);
        #1;
        checks++; if (rdata_b !== 64'h22_00000022) begin errors++; $display("FAIL same_addr: got %h want 0000002200000022", rdata_b); end
        checks++; if (rdata_n[31:0] !== 32'h22) begin errors++; $display("FAIL same_addr_nb: got %h want 22", rdata_n[31:0]); end
    endtask

    task automatic test_bypass();
        rd(5'd9, 5'd7);
        wr(0, 5'd9, 32'h1234);
        #1;
        checks++; if (rdata_b[31:0] !== 32'h1234) begin errors++; $display("FAIL bypass_fwd: got %h want 1234", rdata_b[31:0]); end
        checks++; if (rdata_n[31:0] !== 32'h0) begin errors++; $display("FAIL bypass_off_old: got %h want 0", rdata_n[31:0]); end
        checks++; if (rdata_b[63:32] !== 32'h22) begin errors++; $display("FAIL bypass_other_port: got %h want 22", rdata_b[63:32]); end
        // Port 1 also writes x9 this cycle: highest-index port is forwarded.
        wr(1, 5'd9, 32'h5678);
        #1;
        checks++; if (rdata_b[31:0] !== 32'h5678) begin errors++; $display("FAIL bypass_prio: got %h want 5678", rdata_b[31:0]); end
        tick();
        idle();
        #1;
        checks++; if (rdata_n[31:0] !== 32'h5678) begin errors++; $display("FAIL bypass_nb_next: got %h want 5678", rdata_n[31:0]); end
    endtask

    task automatic test_zero_reg();
        rd(5'd0, 5'd0);
        wr(0, 5'd0, 32'hFFFFFFFF);
        set_en = 1'b1; set_addr = 5'd0;
        #1;
        checks++; if (rdata_b[31:0] !== 32'h0) begin errors++; $display("FAIL zero_fwd: got %h want 0", rdata_b[31:0]); end
        tick();
        idle();
        #1;
        checks++; if (rdata_b !== 64'h0) begin errors++; $display("FAIL zero_read: got %h want 0", rdata_b); end
        checks++; if (rdata_n !== 64'h0) begin errors++; $display("FAIL zero_read_nb: got %h want 0", rdata_n); end
        checks++; if (busy_b[0] !== 1'b0) begin errors++; $display("FAIL zero_busy: got %b want 0", busy_b[0]); end
    endtask

    task automatic test_set_clear();
        rd(5'd3, 5'd4);
        set_en = 1'b1; set_addr = 5'd3;
        tick();
        idle();
        #1;
        checks++; if (busy_b !== 32'h0000_0008) begin errors++; $display("FAIL set_busy: got %h want 00000008", busy_b); end
        checks++; if (rbusy_b !== 2'b01) begin errors++; $display("FAIL set_rbusy: got %b want 01", rbusy_b); end
        // Write x3 while a new producer is issued to x3: reader stays busy.
        wr(0, 5'd3, 32'hAB);
        set_en = 1'b1; set_addr = 5'd3;
        #1;
        checks++; if (rbusy_b[0] !== 1'b1) begin errors++; $display("FAIL set_wins_rbusy: got %b want 1", rbusy_b[0]); end
        tick();
        idle();
        #1;
        checks++; if (busy_b[3] !== 1'b1) begin errors++; $display("FAIL set_wins_busy: got %b want 1", busy_b[3]); end
        checks++; if (rdata_b[31:0] !== 32'hAB) begin errors++; $display("FAIL set_wins_data: got %h want ab", rdata_b[31:0]); end
        // Plain write: forwarded reader sees not-busy only in the bypass build.
        wr(1, 5'd3, 32'hCD);
        #1;
        checks++; if (rbusy_b[0] !== 1'b0) begin errors++; $display("FAIL clr_fwd_rbusy: got %b want 0", rbusy_b[0]); end
        checks++; if (rbusy_n[0] !== 1'b1) begin errors++; $display("FAIL clr_nb_rbusy: got %b want 1", rbusy_n[0]); end
        tick();
        idle();
        #1;
        checks++; if (busy_b !== 32'h0) begin errors++; $display("FAIL clr_busy: got %h want 0", busy_b); end
        checks++; if (rdata_n[31:0] !== 32'hCD) begin errors++; $display("FAIL clr_data: got %h want cd", rdata_n[31:0]); end
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 31; i += 2) begin
            wr(0, 5'(i), 32'h01010101 * i);
            if (i + 1 <= 31) wr(1, 5'(i + 1), 32'h01010101 * (i + 1));
            tick();
            idle();
        end
        set_en = 1'b1; set_addr = 5'd6;
        tick();
        set_addr = 5'd10;
        tick();
        idle(); rd(5'd31, 5'd2);
        #1;
        checks++; if (rdata_b !== 64'h02020202_1F1F1F1F) begin errors++; $display("FAIL populate: got %h want 020202021f1f1f1f", rdata_b); end
        checks++; if (busy_b !== 32'h0000_0440) begin errors++; $display("FAIL populate_busy: got %h want 00000440", busy_b); end
        rst = 1'b1;
        wr(0, 5'd2, 32'h55);
        set_en = 1'b1; set_addr = 5'd4;
        tick();
        rst = 1'b0; idle();
        #1;
        checks++; if (busy_b !== 32'h0) begin errors++; $display("FAIL rst_mid_busy: got %h want 0", busy_b); end
        checks++; if (busy_n !== 32'h0) begin errors++; $display("FAIL rst_mid_busy_nb: got %h want 0", busy_n); end
        for (int a = 0; a < 32; a += 2) begin
            rd(5'(a), 5'(a + 1));
            #1;
            checks++;
            if (rdata_b !== 64'h0 || rdata_n !== 64'h0 || rbusy_b !== 2'b00) begin
                errors++;
                $display("FAIL rst_mid_read x%0d/x%0d: got %h/%h busy %b want 0", a, a + 1, rdata_b, rdata_n, rbusy_b);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_same_addr();
        test_bypass();
        test_zero_reg();
        test_set_clear();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
